// File: rtl/delay_window_sum.sv
// delay_window_sum
//   Running sum of the last DELAY accepted samples, paired with an external
//   reset-less delay line of the same DELAY. A sample is added on entry
//   (idata) and subtracted when it leaves the window (ddata).
//
//   State table
//   state | meaning
//   FILL  | fewer than DELAY samples accepted since reset/clr; ddata ignored
//   RUN   | window full; each accepted sample replaces the oldest one
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   ce     in   sample enable (shared with the delay line)
//   clr    in   synchronous window restart; same-cycle sample discarded
//   idata  in   current sample x[n]
//   ddata  in   delayed sample x[n-DELAY] from the delay line
//   osum   out  registered window sum
//   ovalid out  osum covers a full window
//   ocount out  samples currently in the window (0..DELAY)

module delay_window_sum #(
   parameter  int DELAY = 3,
   parameter  int N     = 8,
   localparam int CW    = $clog2(DELAY + 1),
   localparam int SUM_W = N + CW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             clr,
   input  logic [N-1:0]     idata,
   input  logic [N-1:0]     ddata,
   output logic [SUM_W-1:0] osum,
   output logic             ovalid,
   output logic [CW-1:0]    ocount
);

   typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [SUM_W-1:0] sum_fill;
   logic [SUM_W-1:0] sum_run;

   // Modulo-2^SUM_W arithmetic gives the same truncated result as the
   // SUM_W+1 bit form; the true value is never negative, so no borrow leaks.
   always_comb begin
      sum_fill = osum + SUM_W'(idata);
      sum_run  = osum + SUM_W'(idata) - SUM_W'(ddata);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state  <= FILL;
         osum   <= '0;
         ovalid <= 1'b0;
         ocount <= '0;
      end else if (ce) begin
         case (state)
            FILL: begin
               osum   <= sum_fill;
               ocount <= ocount + CW'(1);
               if (ocount == CW'(DELAY - 1)) begin
                  state  <= RUN;
                  ovalid <= 1'b1;
               end
            end
            RUN: begin
               osum   <= sum_run;
               ocount <= CW'(DELAY);
               ovalid <= 1'b1;
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_window_sum.sv
// Bench for delay_window_sum with DELAY=3, N=8, paired with a behavioural
// reset-less delay line that shifts only on ce.

module tb_delay_window_sum;

   localparam int DELAY = 3;
   localparam int N     = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce  = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  idata = '0;
   logic [7:0]  ddata;
   logic [9:0]  osum;
   logic        ovalid;
   logic [1:0]  ocount;

   int passed = 0;
   int total  = 0;

   // Delay line: no reset, starts with garbage so any use of ddata in FILL shows.
   logic [7:0] dl [DELAY] = '{8'hA5, 8'h5A, 8'hC3};
   assign ddata = dl[DELAY-1];

   always @(posedge clk) begin
      if (ce) begin
         dl[0] <= idata;
         for (int i = 1; i < DELAY; i++) dl[i] <= dl[i-1];
      end
   end

   always #5 clk = ~clk;

   delay_window_sum #(.DELAY(DELAY), .N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .clr    (clr),
      .idata  (idata),
      .ddata  (ddata),
      .osum   (osum),
      .ovalid (ovalid),
      .ocount (ocount)
   );

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic drive(input logic r, input logic c, input logic e, input logic [7:0] d);
      rst = r; clr = c; ce = e; idata = d;
      @(posedge clk);
      #1;
      rst = 1'b0; clr = 1'b0; ce = 1'b0; idata = 8'd0;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 1'b1, 8'd200);
      total++;
      if (osum !== 10'd0 || ovalid !== 1'b0 || ocount !== 2'd0)
         $display("FAIL reset: got sum=%0d valid=%0b count=%0d, expected 0/0/0", osum, ovalid, ocount);
      else passed++;
   endtask

   task automatic test_ramp();
      int es[6] = '{0, 1, 3, 6, 9, 12};
      int ev[6] = '{0, 0, 1, 1, 1, 1};
      int ec[6] = '{1, 2, 3, 3, 3, 3};
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'(i));
         total++;
         if (osum !== 10'(es[i]) || ovalid !== 1'(ev[i]) || ocount !== 2'(ec[i]))
            $display("FAIL ramp[%0d]: got sum=%0d valid=%0b count=%0d, expected %0d/%0d/%0d",
                     i, osum, ovalid, ocount, es[i], ev[i], ec[i]);
         else passed++;
      end
   endtask

   task automatic test_wrap();
      int d[5]  = '{253, 254, 255, 0, 1};
      int es[5] = '{253, 507, 762, 509, 256};
      int ev[5] = '{0, 0, 1, 1, 1};
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'(d[i]));
         total++;
         if (osum !== 10'(es[i]) || ovalid !== 1'(ev[i]))
            $display("FAIL wrap[%0d]: got sum=%0d valid=%0b, expected %0d/%0d",
                     i, osum, ovalid, es[i], ev[i]);
         else passed++;
      end
   endtask

   task automatic test_max();
      int es[5] = '{255, 510, 765, 765, 765};
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'd255);
         total++;
         if (osum !== 10'(es[i]) || ovalid !== (i >= 2))
            $display("FAIL max[%0d]: got sum=%0d valid=%0b, expected %0d/%0b",
                     i, osum, ovalid, es[i], (i >= 2));
         else passed++;
      end
      total++;
      if (osum !== 10'b1011111101 || ocount !== 2'd3)
         $display("FAIL max_bits: got sum=%b count=%0d, expected 1011111101/3", osum, ocount);
      else passed++;
   endtask

   task automatic test_ce_gaps();
      int e[8]  = '{1, 0, 0, 1, 0, 1, 1, 0};
      int es[8] = '{5, 5, 5, 10, 10, 15, 15, 15};
      int ev[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
      int ec[8] = '{1, 1, 1, 2, 2, 3, 3, 3};
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'(e[i]), (e[i] != 0) ? 8'd5 : 8'd99);
         total++;
         if (osum !== 10'(es[i]) || ovalid !== 1'(ev[i]) || ocount !== 2'(ec[i]))
            $display("FAIL ce_gaps[%0d]: got sum=%0d valid=%0b count=%0d, expected %0d/%0d/%0d",
                     i, osum, ovalid, ocount, es[i], ev[i], ec[i]);
         else passed++;
      end
   endtask

   // clr in RUN with ce=1: sample 77 is discarded but still enters the delay line.
   task automatic test_clr_run();
      int c[8]  = '{0, 0, 0, 1, 0, 0, 0, 0};
      int d[8]  = '{3, 4, 5, 77, 1, 2, 3, 4};
      int es[8] = '{3, 7, 12, 0, 1, 3, 6, 9};
      int ev[8] = '{0, 0, 1, 0, 0, 0, 1, 1};
      int ec[8] = '{1, 2, 3, 0, 1, 2, 3, 3};
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'(c[i]), 1'b1, 8'(d[i]));
         total++;
         if (osum !== 10'(es[i]) || ovalid !== 1'(ev[i]) || ocount !== 2'(ec[i]))
            $display("FAIL clr_run[%0d]: got sum=%0d valid=%0b count=%0d, expected %0d/%0d/%0d",
                     i, osum, ovalid, ocount, es[i], ev[i], ec[i]);
         else passed++;
      end
   endtask

   // clr in FILL with ce=0: count restarts, delay line does not shift.
   task automatic test_clr_fill();
      int c[7]  = '{0, 0, 1, 0, 0, 0, 0};
      int e[7]  = '{1, 1, 0, 1, 1, 1, 1};
      int d[7]  = '{9, 9, 0, 1, 1, 1, 2};
      int es[7] = '{9, 18, 0, 1, 2, 3, 4};
      int ev[7] = '{0, 0, 0, 0, 0, 1, 1};
      int ec[7] = '{1, 2, 0, 1, 2, 3, 3};
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'(c[i]), 1'(e[i]), 8'(d[i]));
         total++;
         if (osum !== 10'(es[i]) || ovalid !== 1'(ev[i]) || ocount !== 2'(ec[i]))
            $display("FAIL clr_fill[%0d]: got sum=%0d valid=%0b count=%0d, expected %0d/%0d/%0d",
                     i, osum, ovalid, ocount, es[i], ev[i], ec[i]);
         else passed++;
      end
   endtask

   // rst together with clr and ce mid-RUN, then a fresh window.
   task automatic test_rst_mid();
      int r[8]  = '{0, 0, 0, 1, 0, 0, 0, 0};
      int d[8]  = '{1, 2, 3, 50, 10, 20, 30, 40};
      int es[8] = '{1, 3, 6, 0, 10, 30, 60, 90};
      int ev[8] = '{0, 0, 1, 0, 0, 0, 1, 1};
      int ec[8] = '{1, 2, 3, 0, 1, 2, 3, 3};
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1'(r[i]), 1'(r[i]), 1'b1, 8'(d[i]));
         total++;
         if (osum !== 10'(es[i]) || ovalid !== 1'(ev[i]) || ocount !== 2'(ec[i]))
            $display("FAIL rst_mid[%0d]: got sum=%0d valid=%0b count=%0d, expected %0d/%0d/%0d",
                     i, osum, ovalid, ocount, es[i], ev[i], ec[i]);
         else passed++;
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_ramp();
      test_wrap();
      test_max();
      test_ce_gaps();
      test_clr_run();
      test_clr_fill();
      test_rst_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
